// File: rtl/bus_terminal_fifo.sv
// Bus endpoint with a TX FIFO that the arbiter drains through pndng/pop/D_pop and an
// address-filtered RX FIFO that the bus fills through push/D_push. Both FIFOs are first-word fall-through.

module bus_terminal_fwft #(
   parameter int unsigned width = 16,
   parameter int unsigned depth = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_req,
   input  logic [width-1:0]           push_data,
   input  logic                       pop_req,
   output logic [width-1:0]           head,
   output logic [$clog2(depth+1)-1:0] count,
   output logic                       empty,
   output logic                       dropped
);

   localparam int unsigned ptr_w = $clog2(depth);
   localparam int unsigned cnt_w = $clog2(depth+1);

   logic [width-1:0] mem_q [depth];
   logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0] count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // NOTE: every signal written here gets a default on entry, so no path can leave a latch behind.
   always_comb begin
      full     = (count_q == cnt_w'(depth));
      empty    = (count_q == '0);
      do_pop   = pop_req && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
      do_push  = push_req && (!full || do_pop);
      dropped  = push_req && full && !do_pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
      count_d  = count_q + cnt_w'(do_push) - cnt_w'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the count gates every read, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

module bus_terminal_fifo #(
   parameter int unsigned pckg_sz = 16,
   parameter int unsigned depth   = 8,
   parameter logic [7:0]  id      = 8'd0,
   parameter logic [7:0]  bdcst   = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [pckg_sz-1:0]         wr_data,
   output logic                       tx_full,
   output logic [$clog2(depth+1)-1:0] tx_count,
   input  logic                       rd_en,
   output logic [pckg_sz-1:0]         rd_data,
   output logic                       rx_empty,
   output logic [$clog2(depth+1)-1:0] rx_count,
   output logic                       pndng,
   output logic [pckg_sz-1:0]         D_pop,
   input  logic                       pop,
   input  logic                       push,
   input  logic [pckg_sz-1:0]         D_push,
   output logic                       tx_ovf,
   output logic                       rx_ovf,
   output logic [7:0]                 drop_cnt
);

   localparam int unsigned cnt_w = $clog2(depth+1);

   logic       tx_empty;
   logic       tx_dropped;
   logic       rx_dropped;
   logic       addr_ok;
   logic       misaddr;
   logic       tx_ovf_q, tx_ovf_d;
   logic       rx_ovf_q, rx_ovf_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   assign addr_ok = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == bdcst);
   assign misaddr = push && !addr_ok;

   bus_terminal_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
      .clk       (clk),
      .rst_n     (reset),
      .push_req  (wr_en),
      .push_data (wr_data),
      .pop_req   (pop),
      .head      (D_pop),
      .count     (tx_count),
      .empty     (tx_empty),
      .dropped   (tx_dropped)
   );

   bus_terminal_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
      .clk       (clk),
      .rst_n     (reset),
      .push_req  (push && addr_ok),
      .push_data (D_push),
      .pop_req   (rd_en),
      .head      (rd_data),
      .count     (rx_count),
      .empty     (rx_empty),
      .dropped   (rx_dropped)
   );

   always_comb begin
      tx_ovf_d   = tx_ovf_q || tx_dropped;
      rx_ovf_d   = rx_ovf_q || rx_dropped;
      drop_cnt_d = drop_cnt_q;
      // Overflow and misaddress are mutually exclusive, so at most one increment per cycle.
      if ((rx_dropped || misaddr) && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_ovf_q   <= 1'b0;
         rx_ovf_q   <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         tx_ovf_q   <= tx_ovf_d;
         rx_ovf_q   <= rx_ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pndng    = !tx_empty;
   assign tx_full  = (tx_count == cnt_w'(depth));
   assign tx_ovf   = tx_ovf_q;
   assign rx_ovf   = rx_ovf_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Testbench for bus_terminal_fifo (id=3): directed scenarios plus randomized traffic,
// checked against a queue-based reference model.

module tb_bus_terminal_fifo;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int CW = $clog2(D+1);

   typedef logic [1+1+CW+1+W+1+CW+1+W+8-1:0] snap_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en, rd_en, pop, push;
   logic [W-1:0]  wr_data, D_push;
   logic          tx_full, rx_empty, pndng, tx_ovf, rx_ovf;
   logic [CW-1:0] tx_count, rx_count;
   logic [W-1:0]  rd_data, D_pop;
   logic [7:0]    drop_cnt;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];
   bit           m_tx_ovf, m_rx_ovf;
   int           m_drop;

   always #5 clk = ~clk;

   bus_terminal_fifo #(.pckg_sz(W), .depth(D), .id(8'h03), .bdcst(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
      .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .drop_cnt(drop_cnt)
   );

   function automatic void model_clear();
      tx_q.delete();
      rx_q.delete();
      m_tx_ovf = 0;
      m_rx_ovf = 0;
      m_drop   = 0;
   endfunction

   function automatic snap_t exp_snap();
      return {(tx_q.size() != 0), (tx_q.size() == D), CW'(tx_q.size()), m_tx_ovf,
              (tx_q.size() != 0) ? tx_q[0] : {W{1'b0}},
              (rx_q.size() == 0), CW'(rx_q.size()), m_rx_ovf,
              (rx_q.size() != 0) ? rx_q[0] : {W{1'b0}},
              (m_drop > 255) ? 8'hFF : 8'(m_drop)};
   endfunction

   function automatic snap_t act_snap();
      return {pndng, tx_full, tx_count, tx_ovf, D_pop, rx_empty, rx_count, rx_ovf, rd_data, drop_cnt};
   endfunction

   // Drive one clock of stimulus from a falling edge, advance the model, return at the next falling edge.
   task automatic step(input logic wr, input logic [W-1:0] wd, input logic rd,
                       input logic ps, input logic [W-1:0] dp, input logic pp);
      logic [7:0] dest;
      wr_en = wr; wr_data = wd; rd_en = rd; push = ps; D_push = dp; pop = pp;
      dest = dp[W-1 -: 8];
      if (pp && tx_q.size() > 0) void'(tx_q.pop_front());
      if (wr) begin
         if (tx_q.size() < D) tx_q.push_back(wd);
         else m_tx_ovf = 1;
      end
      if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
      if (ps) begin
         if (dest != 8'h03 && dest != 8'hFF) m_drop++;
         else if (rx_q.size() < D) rx_q.push_back(dp);
         else begin
            m_rx_ovf = 1;
            m_drop++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      wr_en = 0; rd_en = 0; push = 0; pop = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      reset = 1;
      model_clear();
   endtask

   task automatic test_reset();
      snap_t s;
      model_clear();
      #45;
      s = act_snap();
      total++;
      if (s !== exp_snap()) begin
         bad++;
         $display("FAIL reset_during got=%h exp=%h", s, exp_snap());
      end
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      total++;
      if (pndng !== 1'b0 || rx_empty !== 1'b1 || drop_cnt !== 8'd0 || tx_count !== '0 || rx_count !== '0) begin
         bad++;
         $display("FAIL reset_after got pndng=%b rx_empty=%b drop=%0d txc=%0d rxc=%0d exp 0,1,0,0,0",
                  pndng, rx_empty, drop_cnt, tx_count, rx_count);
      end
   endtask

   task automatic test_tx_basic();
      logic [W-1:0] exp_seq [3] = '{16'h0112, 16'h0234, 16'h0356};
      step(1, 16'h0112, 0, 0, '0, 0);
      total++;
      if (pndng !== 1'b1 || D_pop !== 16'h0112) begin
         bad++;
         $display("FAIL tx_first_write got pndng=%b D_pop=%h exp 1/0112", pndng, D_pop);
      end
      step(1, 16'h0234, 0, 0, '0, 0);
      step(1, 16'h0356, 0, 0, '0, 0);
      total++;
      if (tx_count !== CW'(3)) begin
         bad++;
         $display("FAIL tx_count3 got=%0d exp=3", tx_count);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (D_pop !== exp_seq[i]) begin
            bad++;
            $display("FAIL tx_pop_order[%0d] got=%h exp=%h", i, D_pop, exp_seq[i]);
         end
         step(0, '0, 0, 0, '0, 1);
      end
      total++;
      if (pndng !== 1'b0 || tx_count !== '0 || D_pop !== '0) begin
         bad++;
         $display("FAIL tx_drained got pndng=%b cnt=%0d D_pop=%h exp 0/0/0000", pndng, tx_count, D_pop);
      end
      step(0, '0, 0, 0, '0, 1);
      total++;
      if (pndng !== 1'b0 || tx_count !== '0) begin
         bad++;
         $display("FAIL tx_pop_empty got pndng=%b cnt=%0d exp 0/0", pndng, tx_count);
      end
   endtask

   task automatic test_tx_full_wrap();
      logic [W-1:0] e;
      for (int i = 0; i < D; i++) step(1, 16'h0A00 + W'(i), 0, 0, '0, 0);
      total++;
      if (tx_full !== 1'b1 || tx_count !== CW'(D) || tx_ovf !== 1'b0) begin
         bad++;
         $display("FAIL tx_fill got full=%b cnt=%0d ovf=%b exp 1/8/0", tx_full, tx_count, tx_ovf);
      end
      step(1, 16'h0AFF, 0, 0, '0, 0);
      total++;
      if (tx_ovf !== 1'b1 || tx_count !== CW'(D) || D_pop !== 16'h0A00) begin
         bad++;
         $display("FAIL tx_overflow got ovf=%b cnt=%0d D_pop=%h exp 1/8/0A00", tx_ovf, tx_count, D_pop);
      end
      step(1, 16'h0B00, 0, 0, '0, 1);
      total++;
      if (tx_count !== CW'(D) || tx_ovf !== 1'b1 || tx_full !== 1'b1) begin
         bad++;
         $display("FAIL tx_wr_pop_full got cnt=%0d ovf=%b full=%b exp 8/1/1", tx_count, tx_ovf, tx_full);
      end
      for (int i = 0; i < D; i++) begin
         e = (i < D-1) ? 16'h0A01 + W'(i) : 16'h0B00;
         total++;
         if (D_pop !== e) begin
            bad++;
            $display("FAIL tx_wrap_order[%0d] got=%h exp=%h", i, D_pop, e);
         end
         step(0, '0, 0, 0, '0, 1);
      end
      total++;
      if (pndng !== 1'b0) begin
         bad++;
         $display("FAIL tx_wrap_empty got pndng=%b exp 0", pndng);
      end
   endtask

   task automatic test_rx_filter();
      step(0, '0, 0, 1, 16'h03AA, 0);
      step(0, '0, 0, 1, 16'hFFBB, 0);
      step(0, '0, 0, 1, 16'h05CC, 0);
      total++;
      if (rx_count !== CW'(2) || drop_cnt !== 8'd1 || rd_data !== 16'h03AA || rx_empty !== 1'b0) begin
         bad++;
         $display("FAIL rx_filter got cnt=%0d drop=%0d rd=%h empty=%b exp 2/1/03AA/0",
                  rx_count, drop_cnt, rd_data, rx_empty);
      end
      step(0, '0, 1, 0, '0, 0);
      total++;
      if (rd_data !== 16'hFFBB) begin
         bad++;
         $display("FAIL rx_second got=%h exp=FFBB", rd_data);
      end
      step(0, '0, 1, 0, '0, 0);
      step(0, '0, 1, 0, '0, 0);
      total++;
      if (rx_empty !== 1'b1 || rd_data !== '0 || rx_count !== '0) begin
         bad++;
         $display("FAIL rx_drained got empty=%b rd=%h cnt=%0d exp 1/0000/0", rx_empty, rd_data, rx_count);
      end
   endtask

   task automatic test_rx_full();
      logic [W-1:0] e;
      apply_reset();
      for (int i = 0; i < D; i++) step(0, '0, 0, 1, 16'h0300 + W'(i), 0);
      total++;
      if (rx_count !== CW'(D) || rx_ovf !== 1'b0) begin
         bad++;
         $display("FAIL rx_fill got cnt=%0d ovf=%b exp 8/0", rx_count, rx_ovf);
      end
      step(0, '0, 0, 1, 16'h03F0, 0);
      step(0, '0, 0, 1, 16'h03F1, 0);
      total++;
      if (rx_ovf !== 1'b1 || drop_cnt !== 8'd2 || rx_count !== CW'(D)) begin
         bad++;
         $display("FAIL rx_overflow got ovf=%b drop=%0d cnt=%0d exp 1/2/8", rx_ovf, drop_cnt, rx_count);
      end
      step(0, '0, 1, 1, 16'h03F2, 0);
      total++;
      if (rx_count !== CW'(D) || drop_cnt !== 8'd2 || rd_data !== 16'h0301) begin
         bad++;
         $display("FAIL rx_push_rd_full got cnt=%0d drop=%0d rd=%h exp 8/2/0301", rx_count, drop_cnt, rd_data);
      end
      for (int i = 0; i < D; i++) begin
         e = (i < D-1) ? 16'h0301 + W'(i) : 16'h03F2;
         total++;
         if (rd_data !== e) begin
            bad++;
            $display("FAIL rx_order[%0d] got=%h exp=%h", i, rd_data, e);
         end
         step(0, '0, 1, 0, '0, 0);
      end
   endtask

   task automatic test_random();
      int wr_p, pop_p, push_p, rd_p, sel;
      logic [7:0] dest;
      snap_t s;
      apply_reset();
      for (int cyc = 0; cyc < 2400; cyc++) begin
         if (cyc < 800)       begin wr_p = 75; pop_p = 25; push_p = 75; rd_p = 25; end
         else if (cyc < 1600) begin wr_p = 25; pop_p = 75; push_p = 25; rd_p = 75; end
         else                 begin wr_p = 50; pop_p = 50; push_p = 50; rd_p = 50; end
         sel = $urandom_range(0, 2);
         dest = (sel == 0) ? 8'h03 : (sel == 1) ? 8'hFF : 8'($urandom);
         step($urandom_range(0, 99) < wr_p, W'($urandom), $urandom_range(0, 99) < rd_p,
              $urandom_range(0, 99) < push_p, {dest, 8'($urandom)}, $urandom_range(0, 99) < pop_p);
         s = act_snap();
         total++;
         if (s !== exp_snap()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, s, exp_snap());
         end
      end
   endtask

   task automatic test_async_reset();
      snap_t s;
      apply_reset();
      for (int i = 0; i < 5; i++) step(1, 16'h0C00 + W'(i), 0, i < 3, 16'h0330 + W'(i), 0);
      total++;
      if (tx_count !== CW'(5) || rx_count !== CW'(3)) begin
         bad++;
         $display("FAIL async_pre got txc=%0d rxc=%0d exp 5/3", tx_count, rx_count);
      end
      #2 reset = 0;
      #1;
      model_clear();
      s = act_snap();
      total++;
      if (s !== exp_snap()) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", s, exp_snap());
      end
      @(negedge clk);
      reset = 1;
      step(1, 16'h5A5A, 0, 0, '0, 0);
      total++;
      if (pndng !== 1'b1 || D_pop !== 16'h5A5A || tx_count !== CW'(1) || rx_empty !== 1'b1) begin
         bad++;
         $display("FAIL async_post got pndng=%b D_pop=%h txc=%0d rx_empty=%b exp 1/5A5A/1/1",
                  pndng, D_pop, tx_count, rx_empty);
      end
   endtask

   task automatic test_drop_sat();
      for (int i = 0; i < 300; i++) step(0, '0, 0, 1, {8'h07, 8'(i)}, 0);
      total++;
      if (drop_cnt !== 8'hFF || rx_empty !== 1'b1) begin
         bad++;
         $display("FAIL drop_saturate got drop=%0d empty=%b exp 255/1", drop_cnt, rx_empty);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0;
      wr_en = 0; rd_en = 0; push = 0; pop = 0;
      wr_data = '0; D_push = '0;
      test_reset();
      test_tx_basic();
      test_tx_full_wrap();
      test_rx_filter();
      test_rx_full();
      test_random();
      test_async_reset();
      test_drop_sat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
